// File: rtl/int_priority_ctrl_if.sv
// Bus bundle between the interrupt controller and the control unit.
// The master is the control unit side: it drives the request lines, levels,
// masks, the vector-table write port and the ack/done handshake.
// The slave is the controller: it returns intr/intId/intDataOut plus the
// pending latch contents and the current nesting depth.
//   intReq     [NUM_CH]        raw request lines (rising-edge sensitive)
//   intLvl     [NUM_CH*LVL_W]  per-channel priority level
//   intMask    [NUM_CH]        1 = channel enabled for selection
//   intWrite/intSel/intDataIn  vector table write port
//   intAck / intDone           accept interrupt / return from interrupt
//   intr                       registered interrupt request
//   intId / intDataOut         registered winner index and its vector
//   intPending / intDepth      pending latches and nesting depth
interface int_priority_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int LVL_W  = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
);
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEP_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       intReq;
  logic [NUM_CH*LVL_W-1:0] intLvl;
  logic [NUM_CH-1:0]       intMask;
  logic                    intWrite;
  logic [ID_W-1:0]         intSel;
  logic [DATA_W-1:0]       intDataIn;
  logic                    intAck;
  logic                    intDone;
  logic                    intr;
  logic [ID_W-1:0]         intId;
  logic [DATA_W-1:0]       intDataOut;
  logic [NUM_CH-1:0]       intPending;
  logic [DEP_W-1:0]        intDepth;

  modport master (
    output intReq, intLvl, intMask, intWrite, intSel, intDataIn, intAck, intDone,
    input  intr, intId, intDataOut, intPending, intDepth
  );

  modport slave (
    input  intReq, intLvl, intMask, intWrite, intSel, intDataIn, intAck, intDone,
    output intr, intId, intDataOut, intPending, intDepth
  );
endinterface

// File: rtl/int_priority_ctrl.sv
// Parametrised prioritised interrupt controller with nested service.
// Latches rising edges on NUM_CH request lines, selects the most urgent
// eligible channel (highest level, lowest index on ties) and presents it to
// the control unit with a registered intr/intId/intDataOut. An ack pushes the
// current service level and enters the new one; a done pops back out.
// Ports:
//   CLK    system clock, all state changes on the rising edge
//   Reset  synchronous active-high reset
//   bus    int_priority_ctrl_if slave modport (requests, vector table write,
//          ack/done handshake, registered outputs, pending and depth)
module int_priority_ctrl #(
  parameter int NUM_CH = 4,
  parameter int LVL_W  = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  int_priority_ctrl_if.slave  bus
);
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEP_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]       prev_reg;
  logic [NUM_CH-1:0]       pending_reg;
  logic [DATA_W-1:0]       vector_reg [NUM_CH];
  logic [DEPTH-1:0][LVL_W-1:0] stack_reg;
  logic [DEP_W-1:0]        depth_reg;
  logic [LVL_W-1:0]        cur_lvl_reg;
  logic                    intr_reg;
  logic [ID_W-1:0]         id_reg;
  logic [DATA_W-1:0]       data_reg;

  logic [LVL_W-1:0]        lvl [NUM_CH];
  logic [NUM_CH-1:0]       rise;
  logic [NUM_CH-1:0]       elig;
  logic [NUM_CH-1:0]       clr;
  logic                    found;
  logic [LVL_W-1:0]        best_lvl;
  logic [ID_W-1:0]         best_id;
  logic [LVL_W-1:0]        pop_lvl;
  logic                    done_take;
  logic                    ack_take;
  logic                    sel_ok;

  // Done has precedence: a simultaneous ack is dropped and its channel stays pending.
  assign done_take = bus.intDone && (depth_reg != '0);
  assign ack_take  = bus.intAck && intr_reg && !done_take && (depth_reg < DEP_W'(DEPTH));
  assign sel_ok    = {1'b0, bus.intSel} < (ID_W + 1)'(NUM_CH);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign lvl[gi]  = bus.intLvl[gi*LVL_W +: LVL_W];
    assign rise[gi] = bus.intReq[gi] & ~prev_reg[gi];
    assign elig[gi] = pending_reg[gi] & bus.intMask[gi] &
                      ((depth_reg == '0) | (lvl[gi] > cur_lvl_reg));
    assign clr[gi]  = ack_take && (id_reg == ID_W'(gi));
  end

  // Ascending scan with a strict compare keeps the lowest index on level ties.
  always_comb begin
    found    = 1'b0;
    best_lvl = '0;
    best_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (elig[i] && (!found || (lvl[i] > best_lvl))) begin
        found    = 1'b1;
        best_lvl = lvl[i];
        best_id  = ID_W'(i);
      end
    end
  end

  // Level that was active before the current nesting level was entered.
  always_comb begin
    pop_lvl = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == DEP_W'(i + 1)) begin
        pop_lvl = stack_reg[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    // The edge detector tracks the lines even in reset so that a line held
    // high through reset is not mistaken for a fresh request.
    prev_reg <= bus.intReq;
    if (Reset) begin
      pending_reg <= '0;
      stack_reg   <= '0;
      depth_reg   <= '0;
      cur_lvl_reg <= '0;
      intr_reg    <= 1'b0;
      id_reg      <= '0;
      data_reg    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        vector_reg[i] <= '0;
      end
    end else begin
      // Set wins over the ack clear on the same channel.
      pending_reg <= (pending_reg & ~clr) | rise;

      if (bus.intWrite && sel_ok) begin
        vector_reg[bus.intSel] <= bus.intDataIn;
      end

      if (done_take) begin
        depth_reg   <= depth_reg - 1'b1;
        cur_lvl_reg <= pop_lvl;
      end else if (ack_take) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (depth_reg == DEP_W'(i)) begin
            stack_reg[i] <= cur_lvl_reg;
          end
        end
        depth_reg   <= depth_reg + 1'b1;
        cur_lvl_reg <= lvl[id_reg];
      end

      // A handshake edge forces a quiet cycle so the outputs are re-evaluated
      // against the updated depth and level.
      intr_reg <= found && (depth_reg < DEP_W'(DEPTH)) && !ack_take && !done_take;
      if (found) begin
        id_reg   <= best_id;
        data_reg <= vector_reg[best_id];
      end
    end
  end

  assign bus.intr       = intr_reg;
  assign bus.intId      = id_reg;
  assign bus.intDataOut = data_reg;
  assign bus.intPending = pending_reg;
  assign bus.intDepth   = depth_reg;
endmodule
